pattern_detect_ctrl: RTL and testbench



---
 rtl/pattern_detect_ctrl_if.sv | 30 +++
 rtl/pattern_detect_ctrl.sv | 151 +++++++++++++++
 tb/tb_pattern_detect_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_detect_ctrl_if.sv
// Host/config and serial-stream signals of the pattern detector run controller.
interface pattern_detect_ctrl_if #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int LENW   = 4
);
    logic              cfg_we;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic [CNTW-1:0]   cfg_target;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic              in;
    logic              busy;
    logic              match;
    logic [CNTW-1:0]   match_count;
    logic              done;
    logic              err_cfg;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, in_valid, in,
        input  busy, match, match_count, done, err_cfg
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, in_valid, in,
        output busy, match, match_count, done, err_cfg
    );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Run controller for a programmable serial pattern detector: holds the pattern
// configuration, arms/disarms on command, counts overlapping matches and stops
// with done once a non-zero target count is reached.
module pattern_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int LENW   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    pattern_detect_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [MAXLEN-1:0] pat_q, pat_n;
    logic [LENW-1:0]   len_q, len_n;
    logic [CNTW-1:0]   tgt_q, tgt_n;
    logic              cfgv_q, cfgv_n;
    logic              err_q, err_n;
    logic [MAXLEN-1:0] hist_q, hist_n;
    logic [LENW-1:0]   fill_q, fill_n;
    logic [CNTW-1:0]   cnt_q, cnt_n;
    logic              done_q, done_n;
    logic              match_q, match_n;
    logic              busy_q;

    logic              len_ok;
    logic [MAXLEN-1:0] hist_shift;
    logic [LENW-1:0]   fill_inc;
    logic              hit;

    // Ones in the low 'len' bit positions: selects the compared part of history.
    function automatic logic [MAXLEN-1:0] len_mask(input logic [LENW-1:0] len);
        logic [MAXLEN-1:0] m;
        for (int i = 0; i < MAXLEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // Match counter increment that sticks at all-ones in unlimited mode.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    assign len_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LENW'(MAXLEN));
    assign hist_shift = (hist_q << 1) | {{(MAXLEN-1){1'b0}}, bus.in};
    assign fill_inc   = (fill_q < LENW'(MAXLEN)) ? fill_q + {{(LENW-1){1'b0}}, 1'b1} : fill_q;
    // A hit needs at least 'len' bits seen since start, newest bit at position 0.
    assign hit        = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask(len_q)) == '0);

    // Next-state and datapath decisions; priority abort > cfg_we > start > in_valid.
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        len_n   = len_q;
        tgt_n   = tgt_q;
        cfgv_n  = cfgv_q;
        err_n   = err_q;
        hist_n  = hist_q;
        fill_n  = fill_q;
        cnt_n   = cnt_q;
        done_n  = done_q;
        match_n = 1'b0;

        if (bus.abort) begin
            if (state_q != IDLE) begin
                state_n = IDLE;
                done_n  = 1'b0;
            end
        end else begin
            // Config may only change while not armed; a bad length keeps the old config.
            if (bus.cfg_we && (state_q != RUN)) begin
                if (len_ok) begin
                    pat_n  = bus.cfg_pattern;
                    len_n  = bus.cfg_len;
                    tgt_n  = bus.cfg_target;
                    cfgv_n = 1'b1;
                    err_n  = 1'b0;
                end else begin
                    cfgv_n = 1'b0;
                    err_n  = 1'b1;
                end
            end

            // Start sees the config written in this same cycle.
            if (bus.start && (state_q != RUN) && cfgv_n) begin
                state_n = RUN;
                hist_n  = '0;
                fill_n  = '0;
                cnt_n   = '0;
                done_n  = 1'b0;
            end else if ((state_q == RUN) && bus.in_valid) begin
                hist_n = hist_shift;
                fill_n = fill_inc;
                if (hit) begin
                    match_n = 1'b1;
                    cnt_n   = sat_inc(cnt_q);
                    if ((tgt_q != '0) && (cnt_n == tgt_q)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
        end
    end

    // State and configuration registers; reset clears everything including config.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            cfgv_q  <= 1'b0;
            err_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            len_q   <= len_n;
            tgt_q   <= tgt_n;
            cfgv_q  <= cfgv_n;
            err_q   <= err_n;
            hist_q  <= hist_n;
            fill_q  <= fill_n;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
            match_q <= match_n;
            busy_q  <= (state_n == RUN);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.match       = match_q;
    assign bus.match_count = cnt_q;
    assign bus.done        = done_q;
    assign bus.err_cfg     = err_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_pattern_detect_ctrl;
    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;
    localparam int LENW   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    pattern_detect_ctrl_if #(.MAXLEN(MAXLEN), .CNTW(CNTW), .LENW(LENW)) bus();

    pattern_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW), .LENW(LENW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: armed/done flags, stored config, and a queue of bits seen since start.
    bit        m_armed = 0, m_done = 0, m_match = 0, m_err = 0, m_cfgv = 0;
    int        m_cnt = 0, m_len = 0, m_tgt = 0;
    bit [15:0] m_pat = 0;
    bit        m_q[$];

    function automatic bit tail_matches();
        if (m_q.size() < m_len) return 0;
        for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size() - 1 - k] != m_pat[k]) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_armed = 0; m_done = 0; m_match = 0; m_err = 0; m_cfgv = 0;
            m_cnt = 0; m_len = 0; m_tgt = 0; m_pat = 0;
            m_q.delete();
        end else begin
            m_match = 0;
            if (bus.abort) begin
                m_armed = 0;
                m_done = 0;
            end else begin
                if (bus.cfg_we && !m_armed) begin
                    if (bus.cfg_len >= 1 && bus.cfg_len <= MAXLEN) begin
                        m_pat = 16'(bus.cfg_pattern);
                        m_len = int'(bus.cfg_len);
                        m_tgt = int'(bus.cfg_target);
                        m_cfgv = 1; m_err = 0;
                    end else begin
                        m_cfgv = 0; m_err = 1;
                    end
                end
                if (bus.start && !m_armed && m_cfgv) begin
                    m_armed = 1; m_done = 0; m_cnt = 0;
                    m_q.delete();
                end else if (m_armed && bus.in_valid) begin
                    m_q.push_back(bus.in);
                    if (m_q.size() > MAXLEN) void'(m_q.pop_front());
                    if (tail_matches()) begin
                        m_match = 1;
                        if (m_cnt < (1 << CNTW) - 1) m_cnt++;
                        if (m_tgt != 0 && m_cnt == m_tgt) begin
                            m_armed = 0; m_done = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",        32'(bus.busy),        32'(m_armed));
            chk("match",       32'(bus.match),       32'(m_match));
            chk("match_count", 32'(bus.match_count), 32'(m_cnt));
            chk("done",        32'(bus.done),        32'(m_done));
            chk("err_cfg",     32'(bus.err_cfg),     32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        reset = 0;
        bus.cfg_we = 0; bus.start = 0; bus.abort = 0;
        bus.in_valid = 0; bus.in = 0;
    endtask

    task automatic cfg(input logic [MAXLEN-1:0] p, input logic [LENW-1:0] l, input logic [CNTW-1:0] t);
        bus.cfg_we = 1; bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_target = t;
        step();
    endtask

    task automatic go();
        bus.start = 1;
        step();
    endtask

    task automatic abort_run();
        bus.abort = 1;
        step();
    endtask

    task automatic sbit(input logic b);
        bus.in_valid = 1; bus.in = b;
        step();
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
        reset = 1;
        step();
        chk_en = 1;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst match", 32'(bus.match), 0);
        chk("rst count", 32'(bus.match_count), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst err", 32'(bus.err_cfg), 0);

        // 110, target 2: matches after bits 3 and 6, then done.
        cfg(8'b110, 4'd3, 8'd2);
        go();
        chk("t1 busy", 32'(bus.busy), 1);
        sbit(1); sbit(1);
        chk("t1 nomatch", 32'(bus.match), 0);
        sbit(0);
        chk("t1 match1", 32'(bus.match), 1);
        chk("t1 cnt1", 32'(bus.match_count), 1);
        sbit(1); sbit(1); sbit(0);
        chk("t1 match2", 32'(bus.match), 1);
        chk("t1 cnt2", 32'(bus.match_count), 2);
        chk("t1 done", 32'(bus.done), 1);
        chk("t1 busy0", 32'(bus.busy), 0);

        // 1010 unlimited: overlapping matches.
        cfg(8'b1010, 4'd4, 8'd0);
        go();
        sbit(1); sbit(0); sbit(1); sbit(0);
        chk("t2 match1", 32'(bus.match), 1);
        sbit(1);
        chk("t2 gap", 32'(bus.match), 0);
        sbit(0);
        chk("t2 overlap", 32'(bus.match), 1);
        sbit(1);
        chk("t2 cnt", 32'(bus.match_count), 2);
        chk("t2 busy", 32'(bus.busy), 1);
        abort_run();

        // Invalid cycles do not shift or match.
        cfg(8'b110, 4'd3, 8'd0);
        go();
        sbit(1); sbit(1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3 idle", 32'(bus.match), 0);
        end
        sbit(0);
        chk("t3 match", 32'(bus.match), 1);
        abort_run();

        // Abort beats a same-cycle valid bit; restart clears history.
        cfg(8'b110, 4'd3, 8'd5);
        go();
        sbit(1); sbit(1);
        bus.abort = 1; bus.in_valid = 1; bus.in = 0;
        step();
        chk("t4 busy", 32'(bus.busy), 0);
        chk("t4 match", 32'(bus.match), 0);
        chk("t4 cnt", 32'(bus.match_count), 0);
        go();
        sbit(0);
        chk("t4 fresh", 32'(bus.match), 0);
        abort_run();

        // Length validation.
        cfg(8'b11, 4'd0, 8'd0);
        chk("t5 err0", 32'(bus.err_cfg), 1);
        go();
        chk("t5 nostart", 32'(bus.busy), 0);
        cfg(8'b11, 4'd9, 8'd0);
        chk("t5 err9", 32'(bus.err_cfg), 1);
        cfg(8'b11, 4'd2, 8'd0);
        chk("t5 ok", 32'(bus.err_cfg), 0);
        go();
        chk("t5 armed", 32'(bus.busy), 1);
        abort_run();

        // Reset mid-run loses config; config writes in RUN are ignored.
        cfg(8'b11, 4'd2, 8'd3);
        go();
        sbit(1); sbit(1); sbit(1);
        chk("t6 cnt", 32'(bus.match_count), 2);
        reset = 1;
        step();
        chk("t6 busy", 32'(bus.busy), 0);
        chk("t6 cnt0", 32'(bus.match_count), 0);
        go();
        chk("t6 nostart", 32'(bus.busy), 0);
        cfg(8'b11, 4'd2, 8'd0);
        go();
        cfg(8'b00, 4'd0, 8'd0);
        chk("t6 err held", 32'(bus.err_cfg), 0);
        sbit(1); sbit(1);
        chk("t6 pat held", 32'(bus.match), 1);
        abort_run();

        // Unlimited mode saturates the counter while match keeps pulsing.
        cfg(8'b1, 4'd1, 8'd0);
        go();
        for (int i = 0; i < 260; i++) sbit(1);
        chk("sat cnt", 32'(bus.match_count), 255);
        chk("sat match", 32'(bus.match), 1);
        abort_run();

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            bus.abort    = ($urandom_range(0, 39) == 0);
            bus.cfg_we   = ($urandom_range(0, 14) == 0);
            bus.start    = ($urandom_range(0, 9) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in       = 1'($urandom_range(0, 1));
            bus.cfg_pattern = MAXLEN'($urandom);
            bus.cfg_len     = ($urandom_range(0, 7) == 0) ? LENW'($urandom_range(0, 15))
                                                          : LENW'($urandom_range(1, 4));
            bus.cfg_target  = CNTW'($urandom_range(0, 4));
            @(posedge clk);
            #1;
        end
        reset = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
